synapse_scatter: RTL and testbench
==================================

SYNAPSE_SCATTER -- requirements
Module: synapse_scatter

Interface
REQ-001 Parameters SHALL be: N_DEN, default 32, dendrite lanes driven; D_W, default 32, axon/dendrite word width; W_W, default 16, weight width; FRAC, default 8, weight fraction bits (signed Q7.8).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 axon_valid  input  1  axon word offered.
REQ-005 axon  input  D_W  signed axon value from the upstream neuron.
REQ-006 axon_ready  output  1  block can accept an axon word.
REQ-007 wt_we  input  1  weight write strobe.
REQ-008 wt_addr  input  $clog2(N_DEN)  weight index.
REQ-009 wt_data  input  W_W  signed weight.
REQ-010 den  output  N_DEN x D_W  registered signed dendrite values, one word per lane.
REQ-011 den_valid  output  1  one-cycle pulse: all lanes updated for the latest axon word.
REQ-012 busy  output  1  scatter in progress.

Function
REQ-013 Weight file SHALL be N_DEN x W_W registers; wt_we writes wt_data at wt_addr on the clock edge, in any state.
REQ-014 States SHALL be IDLE, SCATTER, DONE; axon_ready = 1 only in IDLE; busy = 1 in SCATTER and DONE.
REQ-015 IDLE: axon_valid && axon_ready captures axon into an internal register, clears lane index to 0, moves to SCATTER.
REQ-016 SCATTER: each cycle lane i SHALL receive (axon_reg * weight[i]) arithmetically shifted right by FRAC, full D_W+W_W-bit signed product, truncation toward negative infinity; index increments.
REQ-017 SCATTER SHALL last exactly N_DEN cycles (lanes 0..N_DEN-1 in order), then move to DONE.
REQ-018 DONE SHALL last one cycle, assert den_valid, and return to IDLE; accept-to-den_valid latency is N_DEN+1 cycles.
REQ-019 Lanes not yet written in the current scatter SHALL hold their previous values.
REQ-020 A weight write to lane i during SCATTER SHALL affect that scatter only if it lands on an edge before lane i is computed; same-edge write and compute uses the old weight.
REQ-021 axon_valid outside IDLE SHALL be ignored (no capture, no state change); upstream holds the word until axon_ready.
REQ-022 Lane index SHALL not wrap past N_DEN-1; back-to-back words give one accept every N_DEN+2 cycles.

Reset
REQ-023 rst SHALL force IDLE, axon_ready=1, busy=0, den_valid=0, all den lanes=0, all weights=0, lane index=0, immediately and independent of clk.
REQ-024 Reset mid-SCATTER SHALL abandon the scatter with no den_valid pulse.

Configuration
REQ-025 Macro SYNAPSE_SAT_EN defined: shifted product outside D_W signed range SHALL clamp to the max positive/max negative D_W value.
REQ-026 SYNAPSE_SAT_EN undefined: shifted product SHALL be truncated to its low D_W bits (two's-complement wrap).

Structure
REQ-027 Package neuron_pkg SHALL hold the state enum type, default N_DEN/D_W/W_W/FRAC constants, and dendrite word typedef, shared with the neuron block.
REQ-028 One sub-module, synapse_mac, SHALL implement multiply, shift and optional saturation combinationally for a single lane; it is instantiated once and time-multiplexed.

Verification
REQ-029 All weights 0x0100 (1.0), axon=1000 -> den_valid at cycle N_DEN+1 after accept, all 32 lanes = 1000.
REQ-030 weight[5]=0xFF80 (-0.5), others 0, axon=-200 -> den[5]=100, other lanes 0.
REQ-031 weight[0]=0x7FFF, axon=0x7FFFFFFF -> with SYNAPSE_SAT_EN den[0]=0x7FFFFFFF; without, den[0]=low 32 bits of (product>>>8).
REQ-032 axon_valid held high for 100 cycles -> exactly 3 accepts (at cycles 0, 34, 68), axon_ready low during busy.
REQ-033 rst asserted at SCATTER lane 10 -> all den 0, no den_valid, axon_ready=1 same cycle; next word scatters normally.
REQ-034 Write weight[20]=0x0200 at SCATTER lane 3 with axon=7 -> den[20]=14; write weight[2] at lane 3 -> den[2] uses old weight.

Source files
------------

// File: rtl/neuron_pkg.sv
// neuron_pkg -- definitions shared between the synapse scatter block and the
// neuron block.
//   * state_t      : scatter controller states (IDLE, SCATTER, DONE)
//   * *_DEF        : default lane count, word widths and weight fraction bits
//   * den_word_t   : one dendrite word at the default width
// No ports (package).
package neuron_pkg;

    localparam int N_DEN_DEF = 32;  // dendrite lanes
    localparam int D_W_DEF   = 32;  // axon / dendrite word width
    localparam int W_W_DEF   = 16;  // weight width
    localparam int FRAC_DEF  = 8;   // weight fraction bits (signed Q7.8)

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCATTER = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef logic signed [D_W_DEF-1:0] den_word_t;

endpackage

// File: rtl/synapse_scatter_if.sv
// synapse_scatter_if -- handshake and data bus of the synapse scatter block.
//   master : upstream side; drives axon_valid/axon and the weight write port,
//            observes axon_ready, den, den_valid, busy.
//   slave  : the scatter block itself.
// Signals:
//   axon_valid / axon / axon_ready : axon word handshake (signed D_W word)
//   wt_we / wt_addr / wt_data      : weight file write port (signed W_W word)
//   den                            : N_DEN registered dendrite words
//   den_valid                      : one-cycle pulse, all lanes updated
//   busy                           : scatter in progress
interface synapse_scatter_if
    import neuron_pkg::*;
#(
    parameter int N_DEN = N_DEN_DEF,
    parameter int D_W   = D_W_DEF,
    parameter int W_W   = W_W_DEF
);
    localparam int AW = (N_DEN > 1) ? $clog2(N_DEN) : 1;

    logic                          axon_valid;
    logic signed [D_W-1:0]         axon;
    logic                          axon_ready;
    logic                          wt_we;
    logic [AW-1:0]                 wt_addr;
    logic signed [W_W-1:0]         wt_data;
    logic [N_DEN-1:0][D_W-1:0]     den;
    logic                          den_valid;
    logic                          busy;

    modport master (
        output axon_valid, axon, wt_we, wt_addr, wt_data,
        input  axon_ready, den, den_valid, busy
    );

    modport slave (
        input  axon_valid, axon, wt_we, wt_addr, wt_data,
        output axon_ready, den, den_valid, busy
    );

endinterface

// File: rtl/synapse_mac.sv
// synapse_mac -- combinational single-lane synapse product.
//   res = (axon * wt) >>> FRAC, computed on the full D_W+W_W-bit signed
//   product; the arithmetic shift floors toward negative infinity.
// Ports:
//   axon : signed D_W axon value
//   wt   : signed W_W weight (FRAC fraction bits)
//   res  : signed D_W lane result
// Build option: define SYNAPSE_SAT_EN to clamp out-of-range results to the
// most positive / most negative D_W value; otherwise the low D_W bits are
// kept (two's-complement wrap).
module synapse_mac
    import neuron_pkg::*;
#(
    parameter int D_W  = D_W_DEF,
    parameter int W_W  = W_W_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic signed [D_W-1:0] axon,
    input  logic signed [W_W-1:0] wt,
    output logic signed [D_W-1:0] res
);

    localparam int P_W = D_W + W_W;

    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] shifted;

    // Size casts of signed operands sign-extend, so the multiply is a true
    // P_W-bit signed product.
    assign prod    = P_W'(axon) * P_W'(wt);
    assign shifted = prod >>> FRAC;

`ifdef SYNAPSE_SAT_EN
    // The result fits in D_W bits when every bit from D_W-1 upward is a copy
    // of the sign bit.
    logic [P_W-D_W:0] hi;
    assign hi = shifted[P_W-1:D_W-1];

    always_comb begin
        res = shifted[D_W-1:0];
        if (!((&hi) || !(|hi))) begin
            if (shifted[P_W-1])
                res = {1'b1, {(D_W-1){1'b0}}};
            else
                res = {1'b0, {(D_W-1){1'b1}}};
        end
    end
`else
    assign res = shifted[D_W-1:0];

    // Upper product bits are discarded by the wrap.
    logic unused_hi;
    assign unused_hi = ^shifted[P_W-1:D_W];
`endif

endmodule

// File: rtl/synapse_scatter.sv
// synapse_scatter -- distributes one axon word to N_DEN dendrite lanes.
// An accepted axon word is multiplied by each lane's weight, one lane per
// cycle through a single shared synapse_mac, lanes 0..N_DEN-1 in order.
// After the last lane a one-cycle DONE state pulses den_valid.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (clears state, weights and lanes)
//   bus : synapse_scatter_if.slave (axon handshake, weight write port,
//         dendrite outputs, den_valid, busy)
// Build option: SYNAPSE_SAT_EN selects saturating lane results (see
// synapse_mac); default is two's-complement wrap.
// Timing: accept at cycle 0, lane i written on the edge closing cycle i+1,
// den_valid in cycle N_DEN+1, next accept possible in cycle N_DEN+2.
module synapse_scatter
    import neuron_pkg::*;
#(
    parameter int N_DEN = N_DEN_DEF,
    parameter int D_W   = D_W_DEF,
    parameter int W_W   = W_W_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    synapse_scatter_if.slave  bus
);

    localparam int             IW   = (N_DEN > 1) ? $clog2(N_DEN) : 1;
    localparam logic [IW-1:0]  LAST = IW'(N_DEN - 1);

    state_t                     state_q, state_d;
    logic [IW-1:0]              idx_q;
    logic signed [D_W-1:0]      axon_q;
    logic [N_DEN-1:0][W_W-1:0]  wt_q;
    logic [N_DEN-1:0][D_W-1:0]  den_q;
    logic signed [D_W-1:0]      lane_res;
    logic                       accept;
    logic                       last_lane;
    logic                       addr_ok;

    assign accept    = (state_q == IDLE) && bus.axon_valid;
    assign last_lane = (idx_q == LAST);

    // ---------------------------------------------------------------------
    // Controller
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        bus.axon_ready = 1'b0;
        bus.busy       = 1'b0;
        bus.den_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.axon_ready = 1'b1;
                if (bus.axon_valid)
                    state_d = SCATTER;
            end
            SCATTER: begin
                bus.busy = 1'b1;
                if (last_lane)
                    state_d = DONE;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.den_valid = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Weight file: writable in any state. The lane being computed reads the
    // registered weight, so a write landing on the same edge is seen only by
    // later scatters.
    // ---------------------------------------------------------------------
    generate
        if ((1 << IW) == N_DEN) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_part
            assign addr_ok = (32'(bus.wt_addr) < N_DEN);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wt_q <= '0;
        else if (bus.wt_we && addr_ok)
            wt_q[bus.wt_addr] <= bus.wt_data;
    end

    // ---------------------------------------------------------------------
    // Datapath: one shared MAC, time-multiplexed across lanes by idx_q.
    // ---------------------------------------------------------------------
    synapse_mac #(
        .D_W  (D_W),
        .W_W  (W_W),
        .FRAC (FRAC)
    ) u_mac (
        .axon (axon_q),
        .wt   (wt_q[idx_q]),
        .res  (lane_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axon_q <= '0;
            idx_q  <= '0;
            den_q  <= '0;
        end else begin
            if (accept) begin
                axon_q <= bus.axon;
                idx_q  <= '0;
            end
            if (state_q == SCATTER) begin
                den_q[idx_q] <= lane_res;
                // Index parks on the last lane; the next accept rewinds it.
                if (!last_lane)
                    idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign bus.den = den_q;

endmodule

// File: tb/tb_synapse_scatter.sv
// tb_synapse_scatter -- self-checking bench for synapse_scatter.
// Directed scenarios plus randomized weight/axon transactions, checked
// against a floor-division reference model of the lane arithmetic.
module tb_synapse_scatter;
    import neuron_pkg::*;

    localparam int N    = 32;
    localparam int DW   = 32;
    localparam int WW   = 16;
    localparam int FRAC = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    synapse_scatter_if #(.N_DEN(N), .D_W(DW), .W_W(WW)) bus ();

    synapse_scatter #(.N_DEN(N), .D_W(DW), .W_W(WW), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    logic [WW-1:0] wt_m  [N];
    logic [DW-1:0] den_m [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Lane result from the arithmetic rules: floor(a*w / 2^FRAC), then
    // clamp or wrap to DW bits.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [WW-1:0] w);
        longint p, q, div, lim;
        div = longint'(1) << FRAC;
        lim = 64'sd2147483648;
        p = longint'($signed(a)) * longint'($signed(w));
        if (p >= 0) q = p / div;
        else        q = -((-p + div - 1) / div);
`ifdef SYNAPSE_SAT_EN
        if (q > lim - 1) return 32'h7FFFFFFF;
        if (q < -lim)    return 32'h80000000;
`endif
        return q[DW-1:0];
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic write_wt(input int a, input logic [WW-1:0] d);
        bus.wt_we   = 1'b1;
        bus.wt_addr = a[$clog2(N)-1:0];
        bus.wt_data = d;
        wt_m[a]     = d;
        step();
        bus.wt_we   = 1'b0;
    endtask

    // Offer one word in the current cycle (cycle 0); returns in cycle 1.
    task automatic start(input logic [DW-1:0] a);
        chk("ready_before_accept", 64'(bus.axon_ready), 64'd1);
        bus.axon_valid = 1'b1;
        bus.axon       = a;
        cyc            = 0;
        step();
        bus.axon_valid = 1'b0;
    endtask

    task automatic finish_scatter(input string tag);
        int early;
        early = 0;
        while (!bus.den_valid && cyc < N + 10) begin
            if (bus.axon_ready) early++;
            step();
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(N + 1));
        chk({tag, "_ready_low_busy"}, 64'(early), 64'd0);
        step();
        chk({tag, "_ready_after"}, 64'(bus.axon_ready), 64'd1);
        chk({tag, "_dv_pulse"}, 64'(bus.den_valid), 64'd0);
    endtask

    task automatic check_all(input string tag, input logic [DW-1:0] a);
        for (int i = 0; i < N; i++) begin
            den_m[i] = model(a, wt_m[i]);
            chk($sformatf("%s_den%0d", tag, i), 64'(bus.den[i]), 64'(den_m[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a;
        int acc[$];
        int bad, dv;

        bus.axon_valid = 1'b0;
        bus.axon       = '0;
        bus.wt_we      = 1'b0;
        bus.wt_addr    = '0;
        bus.wt_data    = '0;
        for (int i = 0; i < N; i++) begin
            wt_m[i]  = '0;
            den_m[i] = '0;
        end

        // Reset state, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", 64'(bus.axon_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_dv", 64'(bus.den_valid), 64'd0);
        chk("rst_den_zero", 64'(|bus.den), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Unity weights
        for (int i = 0; i < N; i++) write_wt(i, 16'h0100);
        start(32'd1000);
        finish_scatter("unity");
        chk("unity_den31", 64'(bus.den[31]), 64'd1000);
        check_all("unity", 32'd1000);

        // Single negative half weight
        for (int i = 0; i < N; i++) write_wt(i, (i == 5) ? 16'hFF80 : 16'h0000);
        start(-32'sd200);
        finish_scatter("half");
        chk("half_den5", 64'(bus.den[5]), 64'd100);
        check_all("half", -32'sd200);

        // Overflow of the shifted product
        write_wt(0, 16'h7FFF);
        start(32'h7FFFFFFF);
        finish_scatter("ovf");
`ifdef SYNAPSE_SAT_EN
        chk("ovf_den0", 64'(bus.den[0]), 64'h7FFFFFFF);
`else
        chk("ovf_den0", 64'(bus.den[0]), 64'hFF7FFF80);
`endif
        check_all("ovf", 32'h7FFFFFFF);

        // Weight write landing mid-scatter: lane 20 still ahead -> new weight
        write_wt(20, 16'h0100);
        write_wt(2, 16'h0100);
        start(32'd7);
        while (cyc < 4) step();
        bus.wt_we = 1'b1; bus.wt_addr = 5'd20; bus.wt_data = 16'h0200;
        step();
        bus.wt_we = 1'b0;
        wt_m[20] = 16'h0200;
        finish_scatter("wr_ahead");
        chk("wr_ahead_den20", 64'(bus.den[20]), 64'd14);
        check_all("wr_ahead", 32'd7);

        // Lane 2 already computed -> old weight for this scatter
        start(32'd7);
        while (cyc < 4) step();
        bus.wt_we = 1'b1; bus.wt_addr = 5'd2; bus.wt_data = 16'h0300;
        step();
        bus.wt_we = 1'b0;
        finish_scatter("wr_behind");
        chk("wr_behind_den2", 64'(bus.den[2]), 64'd7);
        check_all("wr_behind", 32'd7);
        wt_m[2] = 16'h0300;

        // Randomized transactions with mid-scatter hold check
        for (int it = 0; it < 4; it++) begin
            for (int j = 0; j < N; j++)
                if ($urandom_range(0, 1) == 1) write_wt(j, 16'($urandom));
            if (it % 2 == 1) a = $urandom;
            else             a = 32'($signed(16'($urandom)));
            start(a);
            while (cyc < 16) step();
            chk($sformatf("rnd%0d_mid_new3", it), 64'(bus.den[3]), 64'(model(a, wt_m[3])));
            chk($sformatf("rnd%0d_mid_hold20", it), 64'(bus.den[20]), 64'(den_m[20]));
            finish_scatter($sformatf("rnd%0d", it));
            check_all($sformatf("rnd%0d", it), a);
        end

        // axon_valid held for 100 cycles
        a = $urandom;
        bus.axon = a;
        bus.axon_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            if (bus.axon_ready) acc.push_back(c);
            if (bus.axon_ready === bus.busy) bad++;
            step();
        end
        bus.axon_valid = 1'b0;
        chk("hold_accepts", 64'(acc.size()), 64'd3);
        if (acc.size() == 3) begin
            chk("hold_acc0", 64'(acc[0]), 64'd0);
            chk("hold_acc1", 64'(acc[1]), 64'd34);
            chk("hold_acc2", 64'(acc[2]), 64'd68);
        end
        chk("hold_ready_vs_busy", 64'(bad), 64'd0);
        for (int k = 0; k < 50 && !bus.axon_ready; k++) step();
        chk("hold_idle_again", 64'(bus.axon_ready), 64'd1);
        check_all("hold", a);

        // Reset in the middle of a scatter (lane 10 being computed)
        for (int i = 0; i < N; i++) write_wt(i, 16'h0100);
        start(32'd500);
        while (cyc < 11) step();
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_den_zero", 64'(|bus.den), 64'd0);
        chk("mid_rst_ready", 64'(bus.axon_ready), 64'd1);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_dv", 64'(bus.den_valid), 64'd0);
        for (int i = 0; i < N; i++) begin
            wt_m[i]  = '0;
            den_m[i] = '0;
        end
        step();
        rst = 1'b0;
        dv = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.den_valid) dv++;
            step();
        end
        chk("mid_rst_no_dv", 64'(dv), 64'd0);

        // Weights were cleared by reset: a scatter yields zero lanes
        start(32'd123);
        finish_scatter("post_rst_zero");
        check_all("post_rst_zero", 32'd123);

        // Normal operation resumes
        for (int i = 0; i < N; i++) write_wt(i, 16'(i * 64 - 512));
        start(-32'sd5);
        finish_scatter("post_rst");
        check_all("post_rst", -32'sd5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
